// File: rtl/sun_pll_seq_pkg.sv
// Shared types and default timing constants for the ring-oscillator PLL sequencer.
package sun_pll_seq_pkg;

    typedef enum logic [2:0] {
        StOff  = 3'd0,
        StBias = 3'd1,
        StKick = 3'd2,
        StAcq  = 3'd3,
        StLock = 3'd4,
        StCool = 3'd5,
        StFail = 3'd6
    } sun_state_e;

    localparam int unsigned DefBiasCyc    = 64;
    localparam int unsigned DefKickCyc    = 8;
    localparam int unsigned DefLockCnt    = 32;
    localparam int unsigned DefLossCnt    = 4;
    localparam int unsigned DefTimeoutCyc = 4096;
    localparam int unsigned DefOffCyc     = 16;
    localparam int unsigned DefMaxRetry   = 3;

    function automatic logic is_powered(sun_state_e s);
        return (s == StBias) || (s == StKick) || (s == StAcq) || (s == StLock);
    endfunction

endpackage

// File: rtl/sun_pll_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to a selectable value.
module sun_pll_sync2 #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RstVal;
            sync_q <= RstVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sun_pll_seq.sv
// Power-up sequencer and lock detector for the ring-oscillator PLL.
// Define SUN_PLL_SEQ_RETRY_EN to enable cool-down and retry after an acquisition timeout.
module sun_pll_seq
    import sun_pll_seq_pkg::*;
#(
    parameter int unsigned BIAS_CYC    = DefBiasCyc,
    parameter int unsigned KICK_CYC    = DefKickCyc,
    parameter int unsigned LOCK_CNT    = DefLockCnt,
    parameter int unsigned LOSS_CNT    = DefLossCnt,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    parameter int unsigned OFF_CYC     = DefOffCyc,
    parameter int unsigned MAX_RETRY   = DefMaxRetry
) (
    input  logic                           CK,
    input  logic                           RST,
    input  logic                           EN,
    input  logic                           CP_UP_N,
    input  logic                           CP_DOWN,
    output logic                           PWRUP_1V8,
    output logic                           KICK,
    output logic                           LOCKED,
    output logic                           FAIL,
    output logic [$clog2(MAX_RETRY+1)-1:0] RETRY_CNT,
    output logic [2:0]                     STATE
);

    localparam int unsigned PhMax = (BIAS_CYC > KICK_CYC) ?
                                    ((BIAS_CYC > OFF_CYC) ? BIAS_CYC : OFF_CYC) :
                                    ((KICK_CYC > OFF_CYC) ? KICK_CYC : OFF_CYC);
    localparam int unsigned PhW = $clog2(PhMax) + 1;
    localparam int unsigned TmW = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned QcW = $clog2(LOCK_CNT) + 1;
    localparam int unsigned NcW = $clog2(LOSS_CNT) + 1;
    localparam int unsigned RcW = $clog2(MAX_RETRY + 1);

    sun_state_e     state_q, state_d;
    logic [PhW-1:0] ph_q, ph_d, ph_inc;
    logic [TmW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [QcW-1:0] qc_q, qc_d, qc_inc;
    logic [NcW-1:0] nc_q, nc_d, nc_inc;
    logic           pwrup_q, kick_q, locked_q, fail_q;
    logic           up_n_s, down_s, quiet;

    sun_pll_sync2 #(.RstVal(1'b1)) u_sync_up (
        .clk_i(CK), .rst_i(RST), .d_i(CP_UP_N), .q_o(up_n_s)
    );
    sun_pll_sync2 #(.RstVal(1'b0)) u_sync_down (
        .clk_i(CK), .rst_i(RST), .d_i(CP_DOWN), .q_o(down_s)
    );

    assign quiet = up_n_s & ~down_s;

    // Saturating increments: counters hold at their limit instead of wrapping.
    assign ph_inc  = (ph_q == PhW'(PhMax))        ? ph_q  : ph_q + 1'b1;
    assign tmo_inc = (tmo_q == TmW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + 1'b1;
    assign qc_inc  = (qc_q == QcW'(LOCK_CNT))     ? qc_q  : qc_q + 1'b1;
    assign nc_inc  = (nc_q == NcW'(LOSS_CNT))     ? nc_q  : nc_q + 1'b1;

`ifdef SUN_PLL_SEQ_RETRY_EN
    logic [RcW-1:0] retry_q, retry_d;
`endif

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        tmo_d   = tmo_q;
        qc_d    = qc_q;
        nc_d    = nc_q;
`ifdef SUN_PLL_SEQ_RETRY_EN
        retry_d = retry_q;
`endif
        if (!EN) begin
            state_d = StOff;
            ph_d    = '0;
            tmo_d   = '0;
            qc_d    = '0;
            nc_d    = '0;
`ifdef SUN_PLL_SEQ_RETRY_EN
            retry_d = '0;
`endif
        end else begin
            case (state_q)
                StOff: state_d = StBias;
                StBias: begin
                    if (ph_q == PhW'(BIAS_CYC - 1)) begin
                        state_d = StKick;
                        ph_d    = '0;
                    end else ph_d = ph_inc;
                end
                StKick: begin
                    if (ph_q == PhW'(KICK_CYC - 1)) begin
                        state_d = StAcq;
                        ph_d    = '0;
                        tmo_d   = '0;
                        qc_d    = '0;
                    end else ph_d = ph_inc;
                end
                StAcq: begin
                    tmo_d = tmo_inc;
                    qc_d  = quiet ? qc_inc : '0;
                    // Lock takes priority over a coincident timeout.
                    if (quiet && (qc_q == QcW'(LOCK_CNT - 1))) begin
                        state_d = StLock;
                        tmo_d   = '0;
                        qc_d    = '0;
                        nc_d    = '0;
                    end else if (tmo_q == TmW'(TIMEOUT_CYC - 1)) begin
                        tmo_d = '0;
                        qc_d  = '0;
                        ph_d  = '0;
`ifdef SUN_PLL_SEQ_RETRY_EN
                        if (retry_q < RcW'(MAX_RETRY)) begin
                            state_d = StCool;
                            retry_d = retry_q + 1'b1;
                        end else state_d = StFail;
`else
                        state_d = StFail;
`endif
                    end
                end
                StLock: begin
                    nc_d = quiet ? '0 : nc_inc;
                    if (!quiet && (nc_q == NcW'(LOSS_CNT - 1))) begin
                        state_d = StAcq;
                        nc_d    = '0;
                        tmo_d   = '0;
                        qc_d    = '0;
                    end
                end
                StCool: begin
                    if (ph_q == PhW'(OFF_CYC - 1)) begin
                        state_d = StBias;
                        ph_d    = '0;
                    end else ph_d = ph_inc;
                end
                StFail:  state_d = StFail;
                default: state_d = StOff;
            endcase
        end
    end

    // Outputs decode from the next state so they switch on the same edge as the state.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q  <= StOff;
            ph_q     <= '0;
            tmo_q    <= '0;
            qc_q     <= '0;
            nc_q     <= '0;
            pwrup_q  <= 1'b0;
            kick_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            tmo_q    <= tmo_d;
            qc_q     <= qc_d;
            nc_q     <= nc_d;
            pwrup_q  <= is_powered(state_d);
            kick_q   <= (state_d == StKick);
            locked_q <= (state_d == StLock);
            fail_q   <= (state_d == StFail);
        end
    end

`ifdef SUN_PLL_SEQ_RETRY_EN
    always_ff @(posedge CK or posedge RST) begin
        if (RST) retry_q <= '0;
        else     retry_q <= retry_d;
    end
    assign RETRY_CNT = retry_q;
`else
    assign RETRY_CNT = '0;
`endif

    assign PWRUP_1V8 = pwrup_q;
    assign KICK      = kick_q;
    assign LOCKED    = locked_q;
    assign FAIL      = fail_q;
    assign STATE     = state_q;

endmodule
